// File: rtl/beep_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : beep_pkg                                                     |
// | Description : Shared types and constants for the beep burst scheduler:     |
// |               scheduler state encoding, the idle requester index, default  |
// |               interval/pulse settings and small requester-index helpers.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package beep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    // Reported on active_id whenever no burst is playing.
    localparam logic [1:0] IDLE_ID = 2'd3;

    localparam int DEF_ON_TICKS  = 500;
    localparam int DEF_OFF_TICKS = 500;
    localparam int DEF_P0_PULSES = 3;
    localparam int DEF_P1_PULSES = 2;
    localparam int DEF_P2_PULSES = 1;

    // Index of the lowest set bit (bit 0 has priority); IDLE_ID when empty.
    function automatic logic [1:0] lowest_set(input logic [2:0] v);
        if (v[0])      lowest_set = 2'd0;
        else if (v[1]) lowest_set = 2'd1;
        else if (v[2]) lowest_set = 2'd2;
        else           lowest_set = IDLE_ID;
    endfunction

    // One-hot vector for a requester index; all zero for IDLE_ID.
    function automatic logic [2:0] onehot(input logic [1:0] id);
        case (id)
            2'd0:    onehot = 3'b001;
            2'd1:    onehot = 3'b010;
            2'd2:    onehot = 3'b100;
            default: onehot = 3'b000;
        endcase
    endfunction

    // Requesters that outrank the given index.
    function automatic logic [2:0] lower_mask(input logic [1:0] id);
        case (id)
            2'd1:    lower_mask = 3'b001;
            2'd2:    lower_mask = 3'b011;
            default: lower_mask = 3'b000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/beep_tone.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : beep_tone                                                    |
// | Description : Interval timer and tone generator. On restart it begins a    |
// |               fresh ON (tone) or OFF (silent) interval with the tick       |
// |               counter at 0; during ON the buzzer toggles every cycle       |
// |               starting high, during OFF it stays low.                      |
// | Ports       : clk          - system clock, rising edge                     |
// |               rst_n        - synchronous active-low reset                  |
// |               enable       - an interval runs in the coming cycle          |
// |               restart      - start a new interval at this edge             |
// |               tone_on      - kind of interval started (1 = ON, 0 = OFF)    |
// |               beep         - registered buzzer drive                       |
// |               interval_end - current cycle is the last of the interval    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module beep_tone
    import beep_pkg::*;
#(
    parameter int ON_TICKS  = DEF_ON_TICKS,
    parameter int OFF_TICKS = DEF_OFF_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic restart,
    input  logic tone_on,
    output logic beep,
    output logic interval_end
);

    localparam int c_max_ticks = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int c_cnt_w     = (c_max_ticks > 1) ? $clog2(c_max_ticks) : 1;

    localparam logic [c_cnt_w-1:0] c_on_last  = c_cnt_w'(ON_TICKS - 1);
    localparam logic [c_cnt_w-1:0] c_off_last = c_cnt_w'(OFF_TICKS - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_is_on;
    logic               r_run;
    logic               r_beep;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_is_on <= 1'b0;
            r_run   <= 1'b0;
            r_beep  <= 1'b0;
        end else if (restart) begin
            r_cnt   <= '0;
            r_is_on <= tone_on;
            r_run   <= 1'b1;
            r_beep  <= tone_on;          // tone always opens high
        end else if (enable) begin
            r_cnt   <= r_cnt + 1'b1;
            r_beep  <= r_is_on & ~r_beep;
        end else begin
            r_cnt   <= '0;
            r_is_on <= 1'b0;
            r_run   <= 1'b0;
            r_beep  <= 1'b0;
        end
    end

    // Built only from registers so the scheduler can use it to form
    // restart/enable without a combinational loop.
    assign interval_end = r_run & (r_cnt == (r_is_on ? c_on_last : c_off_last));
    assign beep         = r_beep;

endmodule
`default_nettype wire

// File: rtl/beep_sched.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : beep_sched                                                   |
// | Description : Three-requester buzzer burst scheduler. Requests are latched |
// |               as sticky pending bits; the lowest pending index wins and    |
// |               plays Pi_PULSES ON/OFF pulses, bracketed by one-cycle grant  |
// |               and done pulses.                                             |
// | Ports       : clk       - system clock, rising edge                        |
// |               rst_n     - synchronous active-low reset                     |
// |               req[2:0]  - burst requests, bit 0 highest priority           |
// |               beep      - buzzer drive                                     |
// |               busy      - a burst is playing (ON or OFF)                   |
// |               grant[2:0]- one-hot pulse as a burst starts                  |
// |               done[2:0] - one-hot pulse as a burst completes               |
// |               active_id - playing requester, 3 when idle                   |
// | Macro       : BEEP_SCHED_PREEMPT_EN - a higher-priority pending request    |
// |               aborts the playing burst (no done for the aborted one).      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module beep_sched
    import beep_pkg::*;
#(
    parameter int ON_TICKS  = DEF_ON_TICKS,
    parameter int OFF_TICKS = DEF_OFF_TICKS,
    parameter int P0_PULSES = DEF_P0_PULSES,
    parameter int P1_PULSES = DEF_P1_PULSES,
    parameter int P2_PULSES = DEF_P2_PULSES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    output logic       beep,
    output logic       busy,
    output logic [2:0] grant,
    output logic [2:0] done,
    output logic [1:0] active_id
);

    localparam int c_max_p01 = (P0_PULSES > P1_PULSES) ? P0_PULSES : P1_PULSES;
    localparam int c_max_p   = (c_max_p01 > P2_PULSES) ? c_max_p01 : P2_PULSES;
    localparam int c_pw      = (c_max_p > 0) ? $clog2(c_max_p + 1) : 1;

    function automatic logic [c_pw-1:0] pulses_for(input logic [1:0] id);
        case (id)
            2'd0:    pulses_for = c_pw'(P0_PULSES);
            2'd1:    pulses_for = c_pw'(P1_PULSES);
            2'd2:    pulses_for = c_pw'(P2_PULSES);
            default: pulses_for = '0;
        endcase
    endfunction

    state_t          r_state;
    logic [2:0]      r_pending;
    logic [2:0]      r_grant;
    logic [2:0]      r_done;
    logic [1:0]      r_id;
    logic            r_busy;
    logic [c_pw-1:0] r_pulses;

    logic [1:0] w_sel;
    logic       w_start;
    logic [2:0] w_clr;
    logic       w_more;
    logic       w_abort;
    logic       w_interval_end;
    logic       w_on_end;
    logic       w_off_end;
    logic       w_restart;
    logic       w_tone_on;
    logic       w_tone_en;
    logic       w_in_burst;

    assign w_in_burst = (r_state != IDLE);
    assign w_sel      = lowest_set(r_pending);
    assign w_start    = (r_state == IDLE) & (|r_pending);
    assign w_clr      = w_start ? onehot(w_sel) : 3'b000;
    // Remaining count includes the pulse now playing.
    assign w_more     = (r_pulses > c_pw'(1));

`ifdef BEEP_SCHED_PREEMPT_EN
    assign w_abort = w_in_burst & (|(r_pending & lower_mask(r_id)));
`else
    assign w_abort = 1'b0;
`endif

    assign w_on_end  = (r_state == ON)  & w_interval_end & ~w_abort;
    assign w_off_end = (r_state == OFF) & w_interval_end & ~w_abort;

    // The tone block needs to know at this edge what the next cycle holds,
    // so its registered beep is already correct in the first cycle of ON
    // and already low in the first cycle back in IDLE.
    assign w_restart = w_start | w_on_end | (w_off_end & w_more);
    assign w_tone_on = ~w_on_end;
    assign w_tone_en = w_restart | (w_in_burst & ~w_interval_end & ~w_abort);

    beep_tone #(
        .ON_TICKS  (ON_TICKS),
        .OFF_TICKS (OFF_TICKS)
    ) u_tone (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (w_tone_en),
        .restart      (w_restart),
        .tone_on      (w_tone_on),
        .beep         (beep),
        .interval_end (w_interval_end)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pending <= 3'b000;
            r_grant   <= 3'b000;
            r_done    <= 3'b000;
            r_id      <= IDLE_ID;
            r_busy    <= 1'b0;
            r_pulses  <= '0;
        end else begin
            r_grant   <= 3'b000;
            r_done    <= 3'b000;
            // A new request in the grant cycle survives the clear.
            r_pending <= (r_pending & ~w_clr) | req;

            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state  <= ON;
                        r_grant  <= w_clr;
                        r_id     <= w_sel;
                        r_pulses <= pulses_for(w_sel);
                        r_busy   <= 1'b1;
                    end
                end
                ON: begin
                    if (w_abort) begin
                        r_state  <= IDLE;
                        r_id     <= IDLE_ID;
                        r_pulses <= '0;
                        r_busy   <= 1'b0;
                    end else if (w_interval_end) begin
                        r_state  <= OFF;
                    end
                end
                OFF: begin
                    if (w_abort) begin
                        r_state  <= IDLE;
                        r_id     <= IDLE_ID;
                        r_pulses <= '0;
                        r_busy   <= 1'b0;
                    end else if (w_interval_end) begin
                        if (w_more) begin
                            r_state  <= ON;
                            r_pulses <= r_pulses - 1'b1;
                        end else begin
                            r_state  <= IDLE;
                            r_done   <= onehot(r_id);
                            r_id     <= IDLE_ID;
                            r_pulses <= '0;
                            r_busy   <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_id     <= IDLE_ID;
                    r_pulses <= '0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign grant     = r_grant;
    assign done      = r_done;
    assign active_id = r_id;

endmodule
`default_nettype wire

// File: tb/tb_beep_sched.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_beep_sched                                                |
// | Description : Self-checking bench for beep_sched (ON_TICKS=4, OFF_TICKS=2).|
// |               A burst-timeline reference model predicts every cycle's      |
// |               outputs into a queue; a monitor pops and compares them.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_beep_sched;

    localparam int ON_T  = 4;
    localparam int OFF_T = 2;
    localparam int PUL [3] = '{3, 2, 1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] req = 3'b000;
    logic       beep;
    logic       busy;
    logic [2:0] grant;
    logic [2:0] done;
    logic [1:0] active_id;

    beep_sched #(
        .ON_TICKS  (ON_T),
        .OFF_TICKS (OFF_T),
        .P0_PULSES (3),
        .P1_PULSES (2),
        .P2_PULSES (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .beep      (beep),
        .busy      (busy),
        .grant     (grant),
        .done      (done),
        .active_id (active_id)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       beep;
        logic       busy;
        logic [2:0] grant;
        logic [2:0] done;
        logic [1:0] id;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: a burst is a timeline t = cycles since grant;
    // it ends (done, IDLE) when t reaches pulses*(ON+OFF).
    int       m_id   = -1;
    int       m_t    = 0;
    bit [2:0] m_pend = 3'b000;

    task automatic model_step();
        exp_t     e;
        bit [2:0] old;
        bit       abort;
        int       s;
        int       ph;
        old     = m_pend;
        e       = '0;
        e.id    = 2'd3;
        abort   = 1'b0;
        if (!rst_n) begin
            m_pend = 3'b000;
            m_id   = -1;
            m_t    = 0;
        end else begin
            if (m_id < 0) begin
                if (old != 3'b000) begin
                    s = old[0] ? 0 : (old[1] ? 1 : 2);
                    m_id = s;
                    m_t  = 0;
                    e.grant[s] = 1'b1;
                    m_pend[s]  = 1'b0;
                end
            end else begin
`ifdef BEEP_SCHED_PREEMPT_EN
                for (int k = 0; k < m_id; k++)
                    if (old[k]) abort = 1'b1;
`endif
                if (abort) begin
                    m_id = -1;
                end else begin
                    m_t++;
                    if (m_t == PUL[m_id] * (ON_T + OFF_T)) begin
                        e.done[m_id] = 1'b1;
                        m_id = -1;
                    end
                end
            end
            m_pend = m_pend | req;
        end
        if (m_id >= 0) begin
            ph     = m_t % (ON_T + OFF_T);
            e.busy = 1'b1;
            e.id   = m_id[1:0];
            e.beep = (ph < ON_T) && (ph % 2 == 0);
        end
        exp_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: every cycle the DUT presents a full output set.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({beep, busy, grant, done, active_id} !== e) begin
                    n_fail++;
                    $display("FAIL cycle_outputs t=%0t got beep=%b busy=%b grant=%b done=%b id=%0d expected beep=%b busy=%b grant=%b done=%b id=%0d",
                             $time, beep, busy, grant, done, active_id,
                             e.beep, e.busy, e.grant, e.done, e.id);
                end
            end
        end
    end

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req = 3'b000;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 3'b000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single low-priority burst.
        req = 3'b100;
        idle_cycles(12);

        // Two simultaneous requests: 0 then 1 after one IDLE cycle.
        req = 3'b011;
        idle_cycles(40);

        // Higher-priority request arriving during requester 2's ON.
        req = 3'b100;
        idle_cycles(3);
        req = 3'b001;
        idle_cycles(30);

        // Reset during requester 1's second ON.
        req = 3'b010;
        idle_cycles(9);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(12);

        // Requester 1 held for 20 cycles: back-to-back bursts.
        for (int i = 0; i < 20; i++) begin
            req = 3'b010;
            @(negedge clk);
        end
        idle_cycles(40);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 2500; c++) begin
            req   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            rst_n = ($urandom_range(0, 299) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        idle_cycles(60);
        @(negedge clk);
        #1;

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain got %0d leftover entries, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/beep_sched.md
BEEP_SCHED -- requirements
Module: beep_sched

Interface
REQ-001 SHALL have parameter ON_TICKS, default 500, clk cycles per tone-on interval (0.5 s at 1 kHz clk).
REQ-002 SHALL have parameter OFF_TICKS, default 500, clk cycles per silent interval.
REQ-003 SHALL have parameters P0_PULSES=3, P1_PULSES=2, P2_PULSES=1, tone pulses per burst for requesters 0/1/2.
REQ-004 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-006 SHALL have port req  in  3  per-requester burst request, one bit per requester; bit 0 highest priority.
REQ-007 SHALL have port beep  out  1  buzzer drive.
REQ-008 SHALL have port busy  out  1  high while a burst plays.
REQ-009 SHALL have port grant  out  3  one-hot, 1-cycle pulse when a requester's burst starts.
REQ-010 SHALL have port done  out  3  one-hot, 1-cycle pulse when a requester's burst completes.
REQ-011 SHALL have port active_id  out  2  index of the playing requester; 2'd3 when idle.

Function
REQ-012 SHALL keep a sticky pending[2:0]: req[i]=1 sets pending[i]; a grant to i clears it; set wins over a same-cycle clear.
REQ-013 SHALL implement states IDLE, ON, OFF.
REQ-014 In IDLE with pending nonzero, SHALL select the lowest set index i and, at the next edge, enter ON with grant[i]=1 for that cycle, active_id=i, pulse counter loaded with Pi_PULSES.
REQ-015 ON SHALL last exactly ON_TICKS cycles, with beep toggling every cycle starting at 1 (clk/2 tone).
REQ-016 OFF SHALL last exactly OFF_TICKS cycles, with beep=0.
REQ-017 At the end of OFF, SHALL return to ON if pulses remain; otherwise enter IDLE with done[i]=1 for that cycle.
REQ-018 The minimum gap between bursts SHALL be one IDLE cycle; the trailing OFF of the last pulse counts as the inter-burst gap.
REQ-019 A requester reasserting req while its own burst plays SHALL get the burst repeated after completion.
REQ-020 Tick counter width SHALL be $clog2(max(ON_TICKS,OFF_TICKS)) bits; it SHALL restart at 0 on every state entry.
REQ-021 busy SHALL be 1 exactly when the state is ON or OFF.

Reset
REQ-022 rst_n=0 at a rising edge SHALL force state=IDLE, pending=0, counters=0, beep=0, busy=0, grant=0, done=0, active_id=3.
REQ-023 Reset during a burst SHALL abort it silently: no done pulse, and no pending is retained.

Configuration
REQ-024 With macro BEEP_SCHED_PREEMPT_EN defined, a pending bit of lower index than active_id during ON/OFF SHALL abort the current burst: IDLE at the next edge, beep=0, no done for the aborted requester; its pending bit is not restored.
REQ-025 Without BEEP_SCHED_PREEMPT_EN, bursts SHALL always run to completion regardless of pending requests.

Structure
REQ-026 A shared package beep_pkg SHALL hold the state enum (IDLE/ON/OFF), IDLE_ID=2'd3 and default tick/pulse constants.
REQ-027 Tone toggling and the ON/OFF tick counting SHALL live in the sub-module beep_tone (inputs: enable, restart; outputs: beep, interval_end); beep_sched owns arbitration and the pulse counter.

Verification (ON_TICKS=4, OFF_TICKS=2)
REQ-028 Reset, then req=3'b100 for 1 cycle -> grant=3'b100 after 2 edges; beep 1,0,1,0 then 0,0; done=3'b100 at cycle 6 after grant; active_id=3 afterward.
REQ-029 req=3'b011 in the same cycle -> grant[0], 3 pulses, done[0], one IDLE cycle, then grant[1], 2 pulses, done[1].
REQ-030 Preempt off: during requester 2's ON, pulse req[0] -> requester 2 finishes (done[2]), then grant[0]; preempt on: next edge IDLE, no done[2], then grant[0].
REQ-031 rst_n=0 for 1 cycle in requester 1's second ON -> all outputs at reset values next cycle; no grant or done until a new req.
REQ-032 req[1] held high for 20 cycles -> back-to-back bursts for requester 1, each separated by exactly one IDLE cycle.
